// File: rtl/data_memory_pkg.sv
// Shared definitions for the data_memory slice.
// Holds the memory-mapped I/O addresses and the UART serializer state type.
package data_memory_pkg;

  localparam logic [15:0] ADDR_RAM_BASE = 16'h0000;
  localparam logic [15:0] ADDR_LED      = 16'h1000;
  localparam logic [15:0] ADDR_BUT      = 16'h1001;
  localparam logic [15:0] ADDR_UART_TX  = 16'h1002;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/data_memory_if.sv
// CPU-side memory bus for data_memory.
//   address : word address (addressM)
//   load    : write strobe (writeM)
//   in      : write data (outM)
//   out     : combinational read data (inM)
interface data_memory_if;

  logic [15:0] address;
  logic        load;
  logic [15:0] in;
  logic [15:0] out;

  modport master (output address, output load, output in, input out);
  modport slave  (input address, input load, input in, output out);

endinterface

// File: rtl/data_memory_uart_tx_core.sv
// 8N1 UART transmitter.
//   clk, reset : clock, synchronous active-high reset
//   start      : accept data and begin a frame (ignored while busy)
//   data       : byte to send, sampled when start is accepted
//   busy       : high from the first START cycle until the frame ends
//   tx         : serial line, idle high
module uart_tx_core
  import data_memory_pkg::*;
#(
  parameter int BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    unique case (state_q)
      UART_IDLE: begin
        if (start) begin
          data_d  = data;
          state_d = UART_START;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      UART_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = UART_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      UART_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      UART_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = UART_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  // Line level follows the registered state, so it is high the cycle after reset.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      UART_START: tx = 1'b0;
      UART_DATA:  tx = data_q[bit_q];
      default:    tx = 1'b1;
    endcase
  end

  assign busy = (state_q != UART_IDLE);

endmodule

// File: rtl/data_memory.sv
// Hack-style data memory: RAM plus memory-mapped LED, button and UART registers.
//   clk, reset : clock, synchronous active-high reset (RAM is not cleared)
//   bus        : CPU bus (address, load, in, out); out is combinational
//   led        : LED register, written at 0x1000
//   but        : asynchronous buttons, read through a 2-flop synchronizer at 0x1001
//   uart_tx    : serial output; write 0x1002 to send in[7:0], read it for busy
module data_memory
  import data_memory_pkg::*;
#(
  parameter int RAM_WORDS = 2048,
  parameter int BAUD_DIV  = 217
) (
  input  logic            clk,
  input  logic            reset,
  data_memory_if.slave    bus,
  output logic [1:0]      led,
  input  logic [1:0]      but,
  output logic            uart_tx
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [15:0]   ram_mem [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          sel_ram, sel_led, sel_but, sel_uart;
  logic [1:0]    led_q, led_d;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic          uart_start, uart_busy;

  // Full-width compare so addresses past the RAM never alias into it.
  assign sel_ram  = ({1'b0, bus.address} < 17'(RAM_WORDS));
  assign sel_led  = (bus.address == ADDR_LED);
  assign sel_but  = (bus.address == ADDR_BUT);
  assign sel_uart = (bus.address == ADDR_UART_TX);
  assign ram_idx  = bus.address[AW-1:0];

  always_comb begin
    bus.out = '0;
    if (sel_ram) begin
      bus.out = ram_mem[ram_idx];
    end else if (sel_led) begin
      bus.out = {14'b0, led_q};
    end else if (sel_but) begin
      bus.out = {14'b0, sync2_q};
    end else if (sel_uart) begin
      bus.out = {15'b0, uart_busy};
    end
  end

  // RAM writes ignore reset so the CPU can still store during a reset cycle.
  always_ff @(posedge clk) begin
    if (bus.load && sel_ram) begin
      ram_mem[ram_idx] <= bus.in;
    end
  end

  always_comb begin
    led_d   = led_q;
    sync1_d = but;
    sync2_d = sync1_q;
    if (bus.load && sel_led) begin
      led_d = bus.in[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      led_q   <= led_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign led        = led_q;
  assign uart_start = bus.load && sel_uart && !uart_busy && !reset;

  uart_tx_core #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx_core (
    .clk   (clk),
    .reset (reset),
    .start (uart_start),
    .data  (bus.in[7:0]),
    .busy  (uart_busy),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  logic       clk;
  logic       reset;
  logic [1:0] led;
  logic [1:0] but;
  logic       uart_tx;

  int checks = 0;
  int errors = 0;

  data_memory_if bus_if ();

  data_memory #(
    .RAM_WORDS(2048),
    .BAUD_DIV (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .led    (led),
    .but    (but),
    .uart_tx(uart_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic        load;
    logic [15:0] wdata;
    logic        chk_out;
    logic [15:0] exp_out;
    logic [1:0]  exp_led;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic [15:0] a, input logic l,
                              input logic [15:0] w, input logic c, input logic [15:0] e,
                              input logic [1:0] el);
    vec_t v;
    v.name = n; v.addr = a; v.load = l; v.wdata = w;
    v.chk_out = c; v.exp_out = e; v.exp_led = el;
    return v;
  endfunction

  initial begin
    logic [9:0] frame;
    logic [9:0] frame_ff;

    // Expected out is the value seen during the cycle, before any write commits.
    vecs.push_back(mk("wr_5_beef",     16'h0005, 1, 16'hBEEF, 0, 16'h0000, 2'b00));
    vecs.push_back(mk("rd_5_beef",     16'h0005, 0, 16'h0000, 1, 16'hBEEF, 2'b00));
    vecs.push_back(mk("wr_5_old",      16'h0005, 1, 16'h1234, 1, 16'hBEEF, 2'b00));
    vecs.push_back(mk("rd_5_1234",     16'h0005, 0, 16'h0000, 1, 16'h1234, 2'b00));
    vecs.push_back(mk("wr_5_back",     16'h0005, 1, 16'hBEEF, 1, 16'h1234, 2'b00));
    vecs.push_back(mk("wr_7ff",        16'h07FF, 1, 16'hA5A5, 0, 16'h0000, 2'b00));
    vecs.push_back(mk("rd_7ff",        16'h07FF, 0, 16'h0000, 1, 16'hA5A5, 2'b00));
    vecs.push_back(mk("wr_0",          16'h0000, 1, 16'h0001, 0, 16'h0000, 2'b00));
    vecs.push_back(mk("rd_0",          16'h0000, 0, 16'h0000, 1, 16'h0001, 2'b00));
    vecs.push_back(mk("wr_100",        16'h0100, 1, 16'h1111, 0, 16'h0000, 2'b00));
    vecs.push_back(mk("rd_100",        16'h0100, 0, 16'h0000, 1, 16'h1111, 2'b00));
    vecs.push_back(mk("wr_led_ffff",   16'h1000, 1, 16'hFFFF, 1, 16'h0000, 2'b00));
    vecs.push_back(mk("rd_led_3",      16'h1000, 0, 16'h0000, 1, 16'h0003, 2'b11));
    vecs.push_back(mk("wr_led_2",      16'h1000, 1, 16'h0002, 1, 16'h0003, 2'b11));
    vecs.push_back(mk("rd_led_2",      16'h1000, 0, 16'h0000, 1, 16'h0002, 2'b10));
    vecs.push_back(mk("wr_led_ffff2",  16'h1000, 1, 16'hFFFF, 1, 16'h0002, 2'b10));
    vecs.push_back(mk("wr_but_ign",    16'h1001, 1, 16'hFFFF, 1, 16'h0000, 2'b11));
    vecs.push_back(mk("rd_but_0",      16'h1001, 0, 16'h0000, 1, 16'h0000, 2'b11));
    vecs.push_back(mk("wr_2000",       16'h2000, 1, 16'hFFFF, 1, 16'h0000, 2'b11));
    vecs.push_back(mk("rd_2000",       16'h2000, 0, 16'h0000, 1, 16'h0000, 2'b11));
    vecs.push_back(mk("wr_0900",       16'h0900, 1, 16'hFFFF, 1, 16'h0000, 2'b11));
    vecs.push_back(mk("rd_0900",       16'h0900, 0, 16'h0000, 1, 16'h0000, 2'b11));
    vecs.push_back(mk("wr_0800",       16'h0800, 1, 16'hFFFF, 1, 16'h0000, 2'b11));
    vecs.push_back(mk("wr_0fff",       16'h0FFF, 1, 16'hFFFF, 1, 16'h0000, 2'b11));
    vecs.push_back(mk("wr_1003",       16'h1003, 1, 16'hFFFF, 1, 16'h0000, 2'b11));
    vecs.push_back(mk("noalias_100",   16'h0100, 0, 16'h0000, 1, 16'h1111, 2'b11));
    vecs.push_back(mk("noalias_0",     16'h0000, 0, 16'h0000, 1, 16'h0001, 2'b11));
    vecs.push_back(mk("noalias_7ff",   16'h07FF, 0, 16'h0000, 1, 16'hA5A5, 2'b11));
    vecs.push_back(mk("noalias_5",     16'h0005, 0, 16'h0000, 1, 16'hBEEF, 2'b11));
    vecs.push_back(mk("rd_uart_idle",  16'h1002, 0, 16'h0000, 1, 16'h0000, 2'b11));

    // A5 = 1010_0101 sent LSB first between start 0 and stop 1 (index = bit slot).
    frame    = 10'b1_1010_0101_0;
    frame_ff = 10'b1_1111_1111_0;

    reset = 1'b1;
    but   = 2'b00;
    bus_if.address = 16'h0000;
    bus_if.load    = 1'b0;
    bus_if.in      = 16'h0000;
    step();
    step();
    reset = 1'b0;
    chk("rst_led", {14'b0, led}, 16'h0000);
    chk("rst_tx", {15'b0, uart_tx}, 16'h0001);

    for (int i = 0; i < vecs.size(); i++) begin
      bus_if.address = vecs[i].addr;
      bus_if.load    = vecs[i].load;
      bus_if.in      = vecs[i].wdata;
      #1;
      if (vecs[i].chk_out) chk({vecs[i].name, "_out"}, bus_if.out, vecs[i].exp_out);
      chk({vecs[i].name, "_led"}, {14'b0, led}, {14'b0, vecs[i].exp_led});
      step();
      bus_if.load = 1'b0;
    end

    // Reset with load: RAM still written, LED and UART untouched.
    reset = 1'b1;
    bus_if.address = 16'h1000; bus_if.load = 1'b1; bus_if.in = 16'h0003;
    step();
    bus_if.address = 16'h0006; bus_if.in = 16'hCAFE;
    step();
    bus_if.address = 16'h1002; bus_if.in = 16'h00A5;
    step();
    reset = 1'b0;
    bus_if.load = 1'b0;
    #1;
    chk("rstwr_uart_busy", bus_if.out, 16'h0000);
    chk("rstwr_tx", {15'b0, uart_tx}, 16'h0001);
    chk("rstwr_led", {14'b0, led}, 16'h0000);
    bus_if.address = 16'h1000; #1;
    chk("rstwr_led_rd", bus_if.out, 16'h0000);
    bus_if.address = 16'h0006; #1;
    chk("rstwr_ram6", bus_if.out, 16'hCAFE);
    bus_if.address = 16'h0005; #1;
    chk("rst_keeps_ram5", bus_if.out, 16'hBEEF);
    step();

    // Button synchronizer: two-cycle latency.
    bus_if.address = 16'h1001;
    but = 2'b10;
    #1;
    chk("but_cyc1", bus_if.out, 16'h0000);
    step();
    chk("but_cyc2", bus_if.out, 16'h0000);
    step();
    chk("but_cyc3", bus_if.out, 16'h0002);
    step();
    chk("but_cyc4", bus_if.out, 16'h0002);
    but = 2'b00;
    step();
    step();

    // UART frame for 0xA5 with a write attempt while busy.
    bus_if.address = 16'h1002; bus_if.load = 1'b1; bus_if.in = 16'h00A5;
    #1;
    chk("uart_pre_idle", bus_if.out, 16'h0000);
    chk("uart_pre_tx", {15'b0, uart_tx}, 16'h0001);
    step();
    bus_if.load = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k == 12) begin
        bus_if.load = 1'b1; bus_if.in = 16'h0055;
      end
      #1;
      chk($sformatf("a5_tx_%0d", k), {15'b0, uart_tx}, {15'b0, frame[k/4]});
      chk($sformatf("a5_busy_%0d", k), bus_if.out, 16'h0001);
      step();
      bus_if.load = 1'b0;
    end
    chk("a5_done_busy", bus_if.out, 16'h0000);
    chk("a5_done_tx", {15'b0, uart_tx}, 16'h0001);

    // Back-to-back: write on the first idle cycle is accepted.
    bus_if.load = 1'b1; bus_if.in = 16'h00FF;
    step();
    bus_if.load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("ff_tx_%0d", k), {15'b0, uart_tx}, {15'b0, frame_ff[k/4]});
      chk($sformatf("ff_busy_%0d", k), bus_if.out, 16'h0001);
      step();
    end
    // Cycle 10 of the frame: reset aborts it.
    reset = 1'b1;
    #1;
    chk("abort_pre_busy", bus_if.out, 16'h0001);
    step();
    reset = 1'b0;
    #1;
    chk("abort_tx", {15'b0, uart_tx}, 16'h0001);
    chk("abort_busy", bus_if.out, 16'h0000);
    step();
    chk("abort_tx2", {15'b0, uart_tx}, 16'h0001);
    chk("abort_busy2", bus_if.out, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
